snk68_sound_latch: RTL and testbench
====================================

// Module: snk68_sound_latch
// PURPOSE
//  Inter-CPU mailbox between the 68000 and the Z80 sound CPU, driven by the chip-select decoder.
//  - Latch 1 carries 68K->Z80 commands (68K write 0x080000, Z80 read 0xF800).
//  - Latch 2 carries Z80->68K replies (Z80 write 0xF800, 68K read 0x0F8000).
//  - Every 68K command write generates a timed NMI pulse to the Z80.
//  - Pulses that arrive back-to-back are queued, so none is lost.
// PARAMETERS
//  NMI_PULSE_CE  4  Z80 clock enables that z80_nmi_n is held low per pulse (>=1)
//  NMI_GAP_CE    2  Z80 clock enables z80_nmi_n is held high before a queued pulse (>=1)
// PORTS
//  clk               in   1   system clock
//  reset             in   1   synchronous, active-high
//  z80_cen           in   1   Z80 clock enable; NMI timing counts only these cycles
//  m68k_latch_cs     in   1   68K write strobe for latch 1 (already qualified with !rw, !as_n)
//  z80_latch_read_cs in   1   68K read select for latch 2
//  m68k_uds_n        in   1   68K upper data strobe, active low
//  m68k_dout         in   16  68K write data; command byte is [15:8]
//  m68k_din          out  16  {latch2, latch2}, valid while z80_latch_read_cs
//  z80_latch_cs      in   1   Z80 MREQ select at 0xF800
//  z80_rd_n          in   1   Z80 RD, active low
//  z80_wr_n          in   1   Z80 WR, active low
//  z80_dout          in   8   Z80 write data
//  z80_din           out  8   latch1 contents, valid while z80_latch_cs & !z80_rd_n
//  z80_nmi_n         out  1   NMI to Z80, active low, registered
//  latch1_full       out  1   status: command pending, not yet read by Z80
//  latch2_full       out  1   status: reply pending, not yet read by 68K
// BEHAVIOUR
//  Reset values
//  - latch1 and latch2 = 8'h00; z80_nmi_n = 1; both full flags = 0.
//  - State = IDLE; pending = 0; counter = 0.
//  - Reset asserted mid-pulse releases NMI on the next clock edge.
//  Strobe detection
//  - Each strobe is a 1-cycle event taken from the rising edge of its qualified select:
//    - m68k_wr_ev = rise(m68k_latch_cs & !m68k_uds_n)
//    - z80_wr_ev  = rise(z80_latch_cs & !z80_wr_n)
//    - z80_rd_ev  = rise(z80_latch_cs & !z80_rd_n)
//    - m68k_rd_ev = rise(z80_latch_read_cs)
//  - A select held for many clocks produces exactly one event.
//  - Edge detection runs every clk, independent of z80_cen.
//  Latches
//  - On m68k_wr_ev: latch1 <= m68k_dout[15:8] and latch1_full <= 1, one cycle after the event.
//  - On z80_rd_ev: latch1_full <= 0.
//  - If z80_rd_ev and m68k_wr_ev land in the same cycle, the write wins: full stays 1.
//  - z80_wr_ev / m68k_rd_ev set and clear latch2 and latch2_full by the same rules.
//  - Read data paths are combinational from the latch registers, with no read side effects on data.
//  - In a same-cycle write and read, the reader sees the old value.
//  - Writing to a latch whose full flag is set overwrites it (no back-pressure).
//  NMI state machine (counter advances only when z80_cen = 1)
//  - IDLE: z80_nmi_n = 1. On m68k_wr_ev, go to PULSE, cnt = 0.
//  - PULSE: z80_nmi_n = 0.
//    - When cnt == NMI_PULSE_CE-1 on a cen cycle, go to GAP, cnt = 0.
//  - GAP: z80_nmi_n = 1.
//    - When cnt == NMI_GAP_CE-1 on a cen cycle: if pending, go to PULSE and clear pending; else go to IDLE.
//  - m68k_wr_ev while in PULSE or GAP sets pending. Pending is a single bit: extra writes merge into it.
//  - An event in the same cycle as PULSE->GAP is still captured as pending.
//  - z80_nmi_n changes state 1 clk after the triggering event or terminal count.
//  - With z80_cen held low, the NMI level freezes.
// STRUCTURE
//  - Shared package snk68_pkg holds:
//    - typedef nmi_state_t {IDLE, PULSE, GAP}
//    - NMI_PULSE_CE / NMI_GAP_CE defaults
//    - LATCH_W = 8
//  - One sub-module, snk68_rise_det (1-bit registered rising-edge detector), instanced 4x.
//  - Counter width is $clog2(max(NMI_PULSE_CE, NMI_GAP_CE)+1).
// TESTING
//  1. Reset, z80_cen = 1, 68K writes 16'hA5xx with uds_n = 0.
//     -> latch1 = A5, latch1_full = 1.
//     -> z80_nmi_n low for exactly 4 clks, then high.
//  2. 68K writes 16'h12xx, then 16'h34xx while NMI is low.
//     -> two separate NMI pulses of 4 clks each, separated by 2 high clks.
//     -> latch1 = 34.
//  3. Z80 writes 8'h5A to 0xF800, 68K reads 0x0F8000.
//     -> m68k_din = 16'h5A5A; latch2_full goes 1 then 0.
//  4. m68k_latch_cs held for 10 clks with uds_n = 0.
//     -> one NMI pulse only; a write with uds_n = 1 leaves latch1 unchanged and gives no NMI.
//  5. z80_cen = 1 every 3rd clk.
//     -> NMI low for 12 clks; reset asserted mid-pulse -> z80_nmi_n = 1 next clk, latches = 00.
//  6. Same-cycle 68K write and Z80 read of latch1.
//     -> z80_din shows the old value that cycle, latch1_full = 1 afterward.

Source files
------------

// File: rtl/snk68_pkg.sv
// Shared types and constants for the SNK68 68000 <-> Z80 sound mailbox.
package snk68_pkg;

    localparam int unsigned LATCH_W              = 8;
    localparam int unsigned NMI_PULSE_CE_DEFAULT = 4;
    localparam int unsigned NMI_GAP_CE_DEFAULT   = 2;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } nmi_state_t;

endpackage

// File: rtl/snk68_rise_det.sv
// Registered rising-edge detector: one-cycle event on each 0->1 transition of sig_i.
module snk68_rise_det (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/snk68_sound_latch.sv
// Inter-CPU mailbox: 68K->Z80 command latch with queued NMI pulses, Z80->68K reply latch.
module snk68_sound_latch
    import snk68_pkg::*;
#(
    parameter int unsigned NMI_PULSE_CE = NMI_PULSE_CE_DEFAULT,
    parameter int unsigned NMI_GAP_CE   = NMI_GAP_CE_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        z80_cen_i,
    input  logic        m68k_latch_cs_i,
    input  logic        z80_latch_read_cs_i,
    input  logic        m68k_uds_n_i,
    input  logic [15:0] m68k_dout_i,
    output logic [15:0] m68k_din_o,
    input  logic        z80_latch_cs_i,
    input  logic        z80_rd_n_i,
    input  logic        z80_wr_n_i,
    input  logic [7:0]  z80_dout_i,
    output logic [7:0]  z80_din_o,
    output logic        z80_nmi_n_o,
    output logic        latch1_full_o,
    output logic        latch2_full_o
);

    localparam int unsigned CntMax = (NMI_PULSE_CE > NMI_GAP_CE) ? NMI_PULSE_CE : NMI_GAP_CE;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] PulseLast = CntW'(NMI_PULSE_CE - 1);
    localparam logic [CntW-1:0] GapLast   = CntW'(NMI_GAP_CE - 1);

    logic m68k_wr_ev, z80_wr_ev, z80_rd_ev, m68k_rd_ev;

    snk68_rise_det u_m68k_wr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sig_i   (m68k_latch_cs_i & ~m68k_uds_n_i),
        .rise_o  (m68k_wr_ev)
    );

    snk68_rise_det u_z80_wr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sig_i   (z80_latch_cs_i & ~z80_wr_n_i),
        .rise_o  (z80_wr_ev)
    );

    snk68_rise_det u_z80_rd (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sig_i   (z80_latch_cs_i & ~z80_rd_n_i),
        .rise_o  (z80_rd_ev)
    );

    snk68_rise_det u_m68k_rd (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sig_i   (z80_latch_read_cs_i),
        .rise_o  (m68k_rd_ev)
    );

    logic [LATCH_W-1:0] latch1_q, latch2_q;
    logic               latch1_full_q, latch2_full_q;

    // A write and a read landing together leave the flag set: the new data is still unread.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            latch1_q      <= '0;
            latch2_q      <= '0;
            latch1_full_q <= 1'b0;
            latch2_full_q <= 1'b0;
        end else begin
            if (m68k_wr_ev) begin
                latch1_q      <= m68k_dout_i[15:8];
                latch1_full_q <= 1'b1;
            end else if (z80_rd_ev) begin
                latch1_full_q <= 1'b0;
            end
            if (z80_wr_ev) begin
                latch2_q      <= z80_dout_i;
                latch2_full_q <= 1'b1;
            end else if (m68k_rd_ev) begin
                latch2_full_q <= 1'b0;
            end
        end
    end

    nmi_state_t     state_q;
    logic [CntW-1:0] cnt_q;
    logic           pending_q;
    logic           nmi_n_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            nmi_n_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m68k_wr_ev) begin
                        state_q <= PULSE;
                        cnt_q   <= '0;
                        nmi_n_q <= 1'b0;
                    end
                end
                PULSE: begin
                    if (m68k_wr_ev) begin
                        pending_q <= 1'b1;
                    end
                    if (z80_cen_i) begin
                        if (cnt_q == PulseLast) begin
                            state_q <= GAP;
                            cnt_q   <= '0;
                            nmi_n_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (z80_cen_i && cnt_q == GapLast) begin
                        cnt_q <= '0;
                        // A write arriving on the terminal cycle counts as a queued pulse too.
                        if (pending_q || m68k_wr_ev) begin
                            state_q   <= PULSE;
                            nmi_n_q   <= 1'b0;
                            pending_q <= pending_q & m68k_wr_ev;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        if (m68k_wr_ev) begin
                            pending_q <= 1'b1;
                        end
                        if (z80_cen_i) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [7:0] unused_m68k_lo;
    assign unused_m68k_lo = m68k_dout_i[7:0];

    assign m68k_din_o    = z80_latch_read_cs_i ? {latch2_q, latch2_q} : 16'h0000;
    assign z80_din_o     = (z80_latch_cs_i && !z80_rd_n_i) ? latch1_q : 8'h00;
    assign z80_nmi_n_o   = nmi_n_q;
    assign latch1_full_o = latch1_full_q;
    assign latch2_full_o = latch2_full_q;

endmodule

// File: tb/tb_snk68_sound_latch.sv
// Self-checking bench for snk68_sound_latch: vector table, random traffic against a
// transaction-level mailbox model, and hand-written NMI timing sequences.
module tb_snk68_sound_latch;

    localparam int NMI_PULSE_CE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        z80_cen;
    logic        m68k_latch_cs, z80_latch_read_cs, m68k_uds_n;
    logic [15:0] m68k_dout, m68k_din;
    logic        z80_latch_cs, z80_rd_n, z80_wr_n;
    logic [7:0]  z80_dout, z80_din;
    logic        z80_nmi_n, latch1_full, latch2_full;

    snk68_sound_latch dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .z80_cen_i           (z80_cen),
        .m68k_latch_cs_i     (m68k_latch_cs),
        .z80_latch_read_cs_i (z80_latch_read_cs),
        .m68k_uds_n_i        (m68k_uds_n),
        .m68k_dout_i         (m68k_dout),
        .m68k_din_o          (m68k_din),
        .z80_latch_cs_i      (z80_latch_cs),
        .z80_rd_n_i          (z80_rd_n),
        .z80_wr_n_i          (z80_wr_n),
        .z80_dout_i          (z80_dout),
        .z80_din_o           (z80_din),
        .z80_nmi_n_o         (z80_nmi_n),
        .latch1_full_o       (latch1_full),
        .latch2_full_o       (latch2_full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int cen_mode = 0;   // 0: always, 1: every 3rd clk, 2: random
    int m_hold = 0;
    bit mon_en = 1'b0;
    bit tr_q[$];
    int lows_q[$];
    int gaps_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (cen_mode)
            0:       z80_cen = 1'b1;
            1:       z80_cen = (cyc % 3 == 0);
            default: z80_cen = 1'($urandom_range(0, 1));
        endcase
        if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m68k_latch_cs = 1'b0;
        end
    endtask

    // Every completed NMI pulse must span exactly NMI_PULSE_CE Z80 clock enables.
    int  mw = 0;
    bit  in_pulse = 1'b0;
    always @(negedge clk) begin
        if (!mon_en) begin
            in_pulse = 1'b0;
            mw = 0;
        end else if (!z80_nmi_n) begin
            in_pulse = 1'b1;
            if (z80_cen) mw++;
        end else if (in_pulse) begin
            chk("nmi_pulse_cen_width", mw, NMI_PULSE_CE);
            in_pulse = 1'b0;
            mw = 0;
        end
    end

    task automatic m68k_wr_start(input logic [15:0] d, input logic u, input int hold);
        m68k_dout = d;
        m68k_uds_n = u;
        m68k_latch_cs = 1'b1;
        m_hold = hold;
    endtask

    task automatic tr_run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            @(negedge clk);
            tr_q.push_back(z80_nmi_n);
        end
    endtask

    // Split the recorded NMI trace into low-run lengths and the high gaps between them.
    task automatic analyze();
        int run = 0;
        bit lvl = 1'b1;
        bit seen = 1'b0;
        lows_q.delete();
        gaps_q.delete();
        foreach (tr_q[i]) begin
            if (tr_q[i] == lvl) begin
                run++;
            end else begin
                if (!lvl) begin
                    lows_q.push_back(run);
                    seen = 1'b1;
                end else if (seen) begin
                    gaps_q.push_back(run);
                end
                lvl = tr_q[i];
                run = 1;
            end
        end
        if (!lvl) lows_q.push_back(run);
    endtask

    task automatic wait_idle();
        int hi = 0;
        for (int i = 0; i < 300 && hi < 8; i++) begin
            tick();
            @(negedge clk);
            if (z80_nmi_n) hi++; else hi = 0;
        end
        chk("nmi_returns_idle", (hi >= 8), 1);
    endtask

    // op: 0 68K write, 1 Z80 read, 2 Z80 write, 3 68K read, other idle.
    task automatic do_op(input int op, input logic [15:0] d, input logic u, input int hold,
                         output logic [15:0] rdv);
        tick();
        case (op)
            0: begin m68k_dout = d; m68k_uds_n = u; m68k_latch_cs = 1'b1; end
            1: begin z80_latch_cs = 1'b1; z80_rd_n = 1'b0; end
            2: begin z80_dout = d[7:0]; z80_latch_cs = 1'b1; z80_wr_n = 1'b0; end
            3: z80_latch_read_cs = 1'b1;
            default: ;
        endcase
        @(negedge clk);
        rdv = (op == 1) ? {8'h00, z80_din} : m68k_din;
        repeat (hold) tick();
        m68k_latch_cs = 1'b0;
        m68k_uds_n = 1'b1;
        z80_latch_cs = 1'b0;
        z80_rd_n = 1'b1;
        z80_wr_n = 1'b1;
        z80_latch_read_cs = 1'b0;
        tick();
        @(negedge clk);
    endtask

    typedef struct {
        int          op;
        logic [15:0] d;
        logic        u;
        logic        chk_rd;
        logic [15:0] exp;
        logic        f1;
        logic        f2;
    } vec_t;

    vec_t tbl[13];

    logic [15:0] rdv;
    logic [7:0]  m_l1, m_l2;
    logic        m_f1, m_f2;

    initial begin
        tbl[0]  = '{1, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{0, 16'hA5C3, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{1, 16'h0000, 1'b1, 1'b1, 16'h00A5, 1'b0, 1'b0};
        tbl[3]  = '{0, 16'h77FF, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[4]  = '{1, 16'h0000, 1'b1, 1'b1, 16'h00A5, 1'b0, 1'b0};
        tbl[5]  = '{2, 16'h005A, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[6]  = '{3, 16'h0000, 1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0};
        tbl[7]  = '{2, 16'h00C3, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[8]  = '{2, 16'h003C, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[9]  = '{3, 16'h0000, 1'b1, 1'b1, 16'h3C3C, 1'b0, 1'b0};
        tbl[10] = '{0, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[11] = '{0, 16'h5678, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[12] = '{1, 16'h0000, 1'b1, 1'b1, 16'h0056, 1'b0, 1'b0};

        reset = 1'b1;
        z80_cen = 1'b1;
        m68k_latch_cs = 1'b0;
        z80_latch_read_cs = 1'b0;
        m68k_uds_n = 1'b1;
        m68k_dout = 16'h0000;
        z80_latch_cs = 1'b0;
        z80_rd_n = 1'b1;
        z80_wr_n = 1'b1;
        z80_dout = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_nmi_n", z80_nmi_n, 1);
        chk("reset_full1", latch1_full, 0);
        chk("reset_full2", latch2_full, 0);
        mon_en = 1'b1;

        for (int i = 0; i < 13; i++) begin
            do_op(tbl[i].op, tbl[i].d, tbl[i].u, 1, rdv);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), rdv, tbl[i].exp);
            chk($sformatf("tbl%0d_full1", i), latch1_full, tbl[i].f1);
            chk($sformatf("tbl%0d_full2", i), latch2_full, tbl[i].f2);
        end

        // Random traffic; the model only tracks mailbox contents and pending flags.
        m_l1 = 8'h56; m_f1 = 1'b0; m_l2 = 8'h3C; m_f2 = 1'b0;
        cen_mode = 2;
        for (int i = 0; i < 150; i++) begin
            int          op;
            logic [15:0] d;
            logic        u;
            op = int'($urandom_range(0, 4));
            d = 16'($urandom);
            u = ($urandom_range(0, 3) == 0);
            do_op(op, d, u, int'($urandom_range(1, 3)), rdv);
            case (op)
                0: if (!u) begin m_l1 = d[15:8]; m_f1 = 1'b1; end
                1: begin chk($sformatf("rnd%0d_z80_rd", i), rdv, {8'h00, m_l1}); m_f1 = 1'b0; end
                2: begin m_l2 = d[7:0]; m_f2 = 1'b1; end
                3: begin chk($sformatf("rnd%0d_m68k_rd", i), rdv, {m_l2, m_l2}); m_f2 = 1'b0; end
                default: ;
            endcase
            chk($sformatf("rnd%0d_full1", i), latch1_full, m_f1);
            chk($sformatf("rnd%0d_full2", i), latch2_full, m_f2);
        end
        cen_mode = 0;
        wait_idle();

        // Single command: one 4-clk NMI pulse.
        tr_q.delete();
        m68k_wr_start(16'hA500, 1'b0, 1);
        tr_run(12);
        analyze();
        chk("t1_pulses", lows_q.size(), 1);
        if (lows_q.size() > 0) chk("t1_low_len", lows_q[0], 4);
        chk("t1_full1", latch1_full, 1);
        do_op(1, 16'h0, 1'b1, 1, rdv);
        chk("t1_latch1", rdv, 16'h00A5);

        // Second command during the first pulse is queued behind a 2-clk gap.
        tr_q.delete();
        m68k_wr_start(16'h1200, 1'b0, 1);
        tr_run(3);
        m68k_wr_start(16'h3400, 1'b0, 1);
        tr_run(20);
        analyze();
        chk("t2_pulses", lows_q.size(), 2);
        if (lows_q.size() == 2) begin
            chk("t2_low0", lows_q[0], 4);
            chk("t2_low1", lows_q[1], 4);
        end
        if (gaps_q.size() > 0) chk("t2_gap", gaps_q[0], 2);
        else chk("t2_gap_present", gaps_q.size(), 1);
        do_op(1, 16'h0, 1'b1, 1, rdv);
        chk("t2_latch1", rdv, 16'h0034);

        // Long-held select gives one event; uds_n high is ignored.
        tr_q.delete();
        m68k_wr_start(16'h5C00, 1'b0, 10);
        tr_run(30);
        analyze();
        chk("t4_held_pulses", lows_q.size(), 1);
        if (lows_q.size() > 0) chk("t4_held_len", lows_q[0], 4);
        tr_q.delete();
        m68k_wr_start(16'hEE00, 1'b1, 1);
        tr_run(12);
        analyze();
        chk("t4_uds_hi_pulses", lows_q.size(), 0);
        do_op(1, 16'h0, 1'b1, 1, rdv);
        chk("t4_latch1", rdv, 16'h005C);
        wait_idle();

        // Same-cycle 68K write and Z80 read of latch 1.
        do_op(0, 16'h1100, 1'b0, 1, rdv);
        tick();
        m68k_dout = 16'h2200;
        m68k_uds_n = 1'b0;
        m68k_latch_cs = 1'b1;
        z80_latch_cs = 1'b1;
        z80_rd_n = 1'b0;
        @(negedge clk);
        chk("t6_old_data", z80_din, 8'h11);
        tick();
        m68k_latch_cs = 1'b0;
        m68k_uds_n = 1'b1;
        z80_latch_cs = 1'b0;
        z80_rd_n = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_full1_kept", latch1_full, 1);
        do_op(1, 16'h0, 1'b1, 1, rdv);
        chk("t6_new_data", rdv, 16'h0022);
        chk("t6_full1_clr", latch1_full, 0);
        wait_idle();

        // Clock enable every 3rd clk stretches the pulse to 12 clks.
        cen_mode = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (z80_cen) break;
        end
        tr_q.delete();
        m68k_wr_start(16'h9900, 1'b0, 1);
        tr_run(16);
        analyze();
        chk("t5_pulses", lows_q.size(), 1);
        if (lows_q.size() > 0) chk("t5_low_len", lows_q[0], 12);
        do_op(2, 16'h0066, 1'b1, 1, rdv);
        wait_idle();

        // Reset in the middle of a pulse.
        tr_q.delete();
        m68k_wr_start(16'h7700, 1'b0, 1);
        tr_run(4);
        chk("t5_mid_pulse_low", z80_nmi_n, 0);
        mon_en = 1'b0;
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("t5_rst_nmi_n", z80_nmi_n, 1);
        chk("t5_rst_full1", latch1_full, 0);
        chk("t5_rst_full2", latch2_full, 0);
        reset = 1'b0;
        cen_mode = 0;
        do_op(1, 16'h0, 1'b1, 1, rdv);
        chk("t5_rst_latch1", rdv, 16'h0000);
        do_op(3, 16'h0, 1'b1, 1, rdv);
        chk("t5_rst_latch2", rdv, 16'h0000);
        mon_en = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
